// File: rtl/trdb_packet_decoder.sv
// Trace packet decoder: reassembles [header][payload...] byte frames and
// classifies each payload by format/subformat taken from payload byte 0.
module trdb_packet_decoder #(
  parameter int unsigned MAX_BYTES = 16,
  parameter int unsigned CNT_W     = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [7:0]             in_data_i,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [1:0]             out_format_o,
  output logic [1:0]             out_subformat_o,
  output logic [4:0]             out_len_o,
  output logic [8*MAX_BYTES-1:0] out_payload_o,
  output logic                   err_len_o,
  output logic [CNT_W-1:0]       pkt_cnt_o
);

  localparam int unsigned PayloadW = 8 * MAX_BYTES;
  localparam logic [1:0]  FmtSync  = 2'd3;

  typedef enum logic [1:0] {StIdle, StCollect, StDiscard, StHold} state_e;

  state_e              state_q, state_d;
  logic [4:0]          rem_q, rem_d;
  logic [4:0]          idx_q, idx_d;
  // Working buffer is separate from out_payload so delivered values stay
  // stable while the next packet is being collected.
  logic [PayloadW-1:0] buf_q, buf_d;
  logic [PayloadW-1:0] payload_q, payload_d;
  logic [1:0]          fmt_q, fmt_d;
  logic [1:0]          sub_q, sub_d;
  logic [4:0]          len_q, len_d;
  logic                valid_q, valid_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic                accept;
  logic [4:0]          hdr_len;

  assign in_ready_o = (state_q != StHold);
  assign accept     = in_valid_i & in_ready_o;
  assign hdr_len    = in_data_i[4:0];

  // Next-state logic for the FSM and the datapath registers.
  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    idx_d     = idx_q;
    buf_d     = buf_q;
    payload_d = payload_q;
    fmt_d     = fmt_q;
    sub_d     = sub_q;
    len_d     = len_q;
    valid_d   = valid_q;
    err_d     = 1'b0;
    cnt_d     = cnt_q;

    case (state_q)
      StIdle: begin
        if (accept) begin
          if (hdr_len == 5'd0) begin
            err_d = 1'b1;
          end else if (hdr_len > 5'(MAX_BYTES)) begin
            err_d   = 1'b1;
            rem_d   = hdr_len;
            state_d = StDiscard;
          end else begin
            buf_d   = '0;
            rem_d   = hdr_len;
            idx_d   = 5'd0;
            state_d = StCollect;
          end
        end
      end
      StCollect: begin
        if (accept) begin
          for (int unsigned k = 0; k < MAX_BYTES; k++) begin
            if (idx_q == 5'(k)) buf_d[8*k +: 8] = in_data_i;
          end
          idx_d = idx_q + 5'd1;
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) begin
            // Last byte: publish the packet using the just-written buffer.
            state_d   = StHold;
            valid_d   = 1'b1;
            payload_d = buf_d;
            fmt_d     = buf_d[1:0];
            sub_d     = (buf_d[1:0] == FmtSync) ? buf_d[3:2] : 2'd0;
            len_d     = idx_q + 5'd1;
          end
        end
      end
      StDiscard: begin
        if (accept) begin
          rem_d = rem_q - 5'd1;
          if (rem_q == 5'd1) state_d = StIdle;
        end
      end
      StHold: begin
        if (out_ready_i) begin
          valid_d = 1'b0;
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers; reset discards any partial packet.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= StIdle;
      rem_q     <= '0;
      idx_q     <= '0;
      buf_q     <= '0;
      payload_q <= '0;
      fmt_q     <= '0;
      sub_q     <= '0;
      len_q     <= '0;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      idx_q     <= idx_d;
      buf_q     <= buf_d;
      payload_q <= payload_d;
      fmt_q     <= fmt_d;
      sub_q     <= sub_d;
      len_q     <= len_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

  assign out_valid_o     = valid_q;
  assign out_format_o    = fmt_q;
  assign out_subformat_o = sub_q;
  assign out_len_o       = len_q;
  assign out_payload_o   = payload_q;
  assign err_len_o       = err_q;
  assign pkt_cnt_o       = cnt_q;

endmodule
